pe_flit_injector: RTL and testbench
===================================

// Module: pe_flit_injector
// PURPOSE
//  Per-PE traffic source that drives one router LOCAL input port (data_p2r/valid_p2r, backpressure via full).
//  Sits directly upstream of the mesh: one instance per PE, parameterised by node ID.
//  Emits send_num single-flit packets, paced by rate, to destinations from dst_seq.
//  Raises a sticky finish flag when the last flit has been accepted.
// PARAMETERS
//  DATA_WIDTH  32  flit width; must equal the mesh DATA_WIDTH
//  MY_ID       0   3-bit source node ID, placed in every flit
//  TS_W        16  timestamp field width; the free-running cycle counter wraps at 2^TS_W
// PORTS
//  clk               in   1           clock
//  rst_n             in   1           synchronous active-low reset
//  enable            in   1           start a task; sampled in IDLE only
//  flush             in   1           synchronous abort/clear; higher priority than enable
//  mode              in   4           [0]=0: cycle through dst_seq; [0]=1: always dst_seq[2:0]; [3:1] reserved
//  send_num          in   3           flits per task (0 = empty task)
//  rate              in   4           idle gap in cycles between accepted flits
//  dst_seq           in   24          8 x 3-bit destination IDs, entry k at [3k+2:3k]
//  full              in   1           router local FIFO full; no transfer while high
//  data_p2r          out  DATA_WIDTH  flit to router
//  valid_p2r         out  1           flit valid
//  task_send_finish  out  1           sticky: every flit of the task accepted
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): state=IDLE; valid_p2r=0; data_p2r=0; task_send_finish=0;
//    sent count, dst index, gap counter and timestamp counter all 0.
//  - Transfer = the cycle in which valid_p2r && !full. When it happens, the next flit is built next cycle.
//  - While valid_p2r=1 and full=1: data_p2r and valid_p2r hold stable. valid never drops without a transfer, except on flush/reset.
//  - Flit: [31:29] dst, [28:26] MY_ID, [25:23] sequence no. (sent count), [22:TS_W] 0, [TS_W-1:0] timestamp at the cycle valid first rises.
//  - FSM:
//    - IDLE: on enable with send_num!=0 -> SEND; latch send_num, rate, mode, dst_seq.
//      On enable with send_num==0 -> DONE directly, no flit.
//    - SEND: valid_p2r=1. On transfer: sent++.
//      If sent+1==send_num -> DONE; else if rate==0 -> stay in SEND with the next flit (back-to-back); else -> GAP.
//    - GAP: valid_p2r=0; count rate cycles, then -> SEND.
//    - DONE: task_send_finish=1, held until flush; enable is ignored.
//  - Destination: mode[0]=0 -> dst_seq[idx], idx increments per transfer and wraps 7->0. mode[0]=1 -> dst_seq[2:0] always.
//  - Latency: enable seen at edge N -> valid_p2r=1 after edge N+1. Last transfer at edge M -> finish=1 after edge M+1.
//  - Flush: at the next edge, return to IDLE with every output and counter at its reset value (timestamp excepted).
//    A flit in flight is dropped; flush and transfer in the same cycle count as a flush.
//  - Config inputs changing mid-task have no effect; latched copies are used.
//  - Destination == MY_ID is legal and sent unchanged.
//  - The timestamp counter runs in every state and wraps silently.
// STRUCTURE
//  - noc_pkg: DATA_WIDTH, NODE_ID_W=3, flit_t packed struct {dst, src, seq, rsvd, ts}, inj_state_e enum.
//  - One sub-module, inj_pacer: gap counter (load rate, count down, done pulse).
//  - FSM, flit build and output register stay in this module.
// TESTING
//  1. Reset mid-SEND with full=1 -> after the edge valid_p2r=0, data_p2r=0, finish=0.
//  2. MY_ID=3, send_num=4, rate=0, full=0, mode=0, dst_seq={7,6,5,4,3,2,1,0}
//     -> 4 consecutive valid cycles, dst 0,1,2,3, seq 0..3, src=3; finish one cycle after the last flit.
//  3. send_num=2, rate=3, full=0 -> flits accepted at cycles t and t+4; valid low for exactly 3 cycles in between.
//  4. full=1 for 5 cycles while valid -> data_p2r constant over all 5; one transfer after full drops; sent count +1 only.
//  5. send_num=7, mode=1, dst_seq[2:0]=5 -> all 7 flits dst=5.
//     Separately, send_num=0 -> finish after 1 cycle with no valid.
//  6. Flush during GAP with 3 flits left -> IDLE, finish=0; re-enable restarts at seq 0, idx 0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared types and constants for the PE-side flit injector.
package noc_pkg;

    localparam int FLIT_W    = 32;
    localparam int NODE_ID_W = 3;
    localparam int TS_WIDTH  = 16;
    localparam int SEQ_W     = 3;
    localparam int RATE_W    = 4;
    localparam int IDX_W     = 3;
    localparam int DST_SEQ_W = 8 * NODE_ID_W;

    // Flit layout from MSB down: destination, source, sequence, zero pad, timestamp.
    typedef struct packed {
        logic [NODE_ID_W-1:0]                            dst;
        logic [NODE_ID_W-1:0]                            src;
        logic [SEQ_W-1:0]                                seq;
        logic [FLIT_W-2*NODE_ID_W-SEQ_W-TS_WIDTH-1:0]    rsvd;
        logic [TS_WIDTH-1:0]                             ts;
    } flit_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } inj_state_e;

    // Task configuration captured when a task starts.
    typedef struct packed {
        logic [SEQ_W-1:0]     send_num;
        logic [RATE_W-1:0]    rate;
        logic                 fixed_dst;
        logic [DST_SEQ_W-1:0] dst_seq;
    } inj_cfg_t;

    // Destination for the flit at destination-list position idx.
    function automatic logic [NODE_ID_W-1:0] pick_dst(input inj_cfg_t cfg, input logic [IDX_W-1:0] idx);
        logic [NODE_ID_W-1:0] d;
        d = cfg.dst_seq[NODE_ID_W*int'(idx) +: NODE_ID_W];
        if (cfg.fixed_dst) begin
            d = cfg.dst_seq[NODE_ID_W-1:0];
        end
        return d;
    endfunction

endpackage

// File: rtl/inj_pacer.sv
// Inter-flit gap counter: loaded with the idle gap, counts down, and flags
// the last idle cycle so the FSM re-enters SEND exactly rate cycles later.
module inj_pacer
    import noc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [RATE_W-1:0] rate_i,
    output logic              done_o
);

    logic [RATE_W-1:0] cnt_q;
    logic [RATE_W-1:0] cnt_d;

    // Next count: clear wins over load, load wins over the countdown.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = rate_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - RATE_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == RATE_W'(1));

endmodule

// File: rtl/pe_flit_injector.sv
// Per-PE traffic source feeding one router LOCAL port. Emits a task of
// single-flit packets, paced by an idle gap, and raises a sticky finish flag.
module pe_flit_injector
    import noc_pkg::*;
#(
    parameter int                   DATA_WIDTH = FLIT_W,
    parameter logic [NODE_ID_W-1:0] MY_ID      = '0,
    parameter int                   TS_W       = TS_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  flush,
    input  logic [3:0]            mode,
    input  logic [SEQ_W-1:0]      send_num,
    input  logic [RATE_W-1:0]     rate,
    input  logic [DST_SEQ_W-1:0]  dst_seq,
    input  logic                  full,
    output logic [DATA_WIDTH-1:0] data_p2r,
    output logic                  valid_p2r,
    output logic                  task_send_finish
);

    inj_state_e            state_q, state_d;
    inj_cfg_t              cfg_q, cfg_d, cfg_in;
    logic [SEQ_W-1:0]      sent_q, sent_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [TS_W-1:0]       ts_q, ts_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  finish_q, finish_d;
    logic                  xfer;
    logic                  last_flit;
    logic                  pace_load;
    logic                  pace_done;
    logic                  unused_mode;

    // mode[3:1] is reserved and deliberately ignored.
    assign unused_mode = ^mode[3:1];
    assign cfg_in      = {send_num, rate, mode[0], dst_seq};
    assign xfer        = valid_q && !full;
    assign last_flit   = (({1'b0, sent_q} + (SEQ_W+1)'(1)) == {1'b0, cfg_q.send_num});
    // A freshly built flit carries the counter value of the cycle it first appears in.
    assign ts_d        = ts_q + TS_W'(1);

    function automatic logic [DATA_WIDTH-1:0] build_flit(
        input logic [NODE_ID_W-1:0] dst,
        input logic [SEQ_W-1:0]     seq,
        input logic [TS_W-1:0]      ts
    );
        logic [DATA_WIDTH-1:0] f;
        f = '0;
        f[DATA_WIDTH-1 -: NODE_ID_W]             = dst;
        f[DATA_WIDTH-1-NODE_ID_W -: NODE_ID_W]   = MY_ID;
        f[DATA_WIDTH-1-2*NODE_ID_W -: SEQ_W]     = seq;
        f[TS_W-1:0]                              = ts;
        return f;
    endfunction

    inj_pacer u_pacer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (flush),
        .load_i  (pace_load),
        .rate_i  (cfg_q.rate),
        .done_o  (pace_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = (send_num == '0) ? ST_DONE : ST_SEND;
                end
            end
            ST_SEND: begin
                if (xfer) begin
                    if (last_flit) begin
                        state_d = ST_DONE;
                    end else if (cfg_q.rate != '0) begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (pace_done) begin
                    state_d = ST_SEND;
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    // Output and datapath next values: flit build, counters, finish flag.
    always_comb begin
        cfg_d     = cfg_q;
        sent_d    = sent_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        data_d    = data_q;
        finish_d  = finish_q;
        pace_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    cfg_d  = cfg_in;
                    sent_d = '0;
                    idx_d  = '0;
                    if (send_num != '0) begin
                        valid_d = 1'b1;
                        data_d  = build_flit(pick_dst(cfg_in, '0), '0, ts_d);
                    end else begin
                        finish_d = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (xfer) begin
                    sent_d = sent_q + SEQ_W'(1);
                    idx_d  = idx_q + IDX_W'(1);
                    if (last_flit) begin
                        valid_d  = 1'b0;
                        data_d   = '0;
                        finish_d = 1'b1;
                    end else if (cfg_q.rate == '0) begin
                        data_d = build_flit(pick_dst(cfg_q, idx_d), sent_d, ts_d);
                    end else begin
                        valid_d   = 1'b0;
                        data_d    = '0;
                        pace_load = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (pace_done) begin
                    valid_d = 1'b1;
                    data_d  = build_flit(pick_dst(cfg_q, idx_q), sent_q, ts_d);
                end
            end
            ST_DONE: finish_d = 1'b1;
            default: ;
        endcase
        // A flit in flight is dropped; flush also beats a same-cycle transfer.
        if (flush) begin
            cfg_d     = '0;
            sent_d    = '0;
            idx_d     = '0;
            valid_d   = 1'b0;
            data_d    = '0;
            finish_d  = 1'b0;
            pace_load = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_q    <= '0;
            sent_q   <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            finish_q <= 1'b0;
        end else begin
            cfg_q    <= cfg_d;
            sent_q   <= sent_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            finish_q <= finish_d;
        end
    end

    // Free-running timestamp counter; only reset clears it, flush does not.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end

    assign data_p2r         = data_q;
    assign valid_p2r        = valid_q;
    assign task_send_finish = finish_q;

endmodule

// File: tb/tb_pe_flit_injector.sv
// Self-checking bench for pe_flit_injector: table of directed tasks, hand-written
// stall/reset/flush sequences, and randomized tasks against a transaction model.
module tb_pe_flit_injector;
    import noc_pkg::*;

    localparam logic [2:0] MY_ID = 3'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        flush;
    logic [3:0]  mode;
    logic [2:0]  send_num;
    logic [3:0]  rate;
    logic [23:0] dst_seq;
    logic        full;
    logic [31:0] data_p2r;
    logic        valid_p2r;
    logic        task_send_finish;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] tb_cyc;

    pe_flit_injector #(
        .DATA_WIDTH (32),
        .MY_ID      (MY_ID),
        .TS_W       (16)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .flush            (flush),
        .mode             (mode),
        .send_num         (send_num),
        .rate             (rate),
        .dst_seq          (dst_seq),
        .full             (full),
        .data_p2r         (data_p2r),
        .valid_p2r        (valid_p2r),
        .task_send_finish (task_send_finish)
    );

    always #5 clk = ~clk;

    // Reference timestamp: cycles elapsed since reset, wrapping at 2^16.
    always @(posedge clk) begin
        if (!rst_n) tb_cyc <= '0;
        else        tb_cyc <= tb_cyc + 16'd1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Destination of the k-th flit of a task, straight from the mode/dst_seq rules.
    function automatic logic [2:0] model_dst(input logic [3:0] md, input logic [23:0] ds, input int k);
        logic [23:0] s;
        s = ds >> (3 * (md[0] ? 0 : (k % 8)));
        return s[2:0];
    endfunction

    task automatic check_new_flit(input int k, input logic [3:0] md, input logic [23:0] ds,
                                  input int gap, input int exp_gap);
        flit_t f;
        f = data_p2r;
        check("flit_dst",  32'(f.dst),  32'(model_dst(md, ds, k)));
        check("flit_src",  32'(f.src),  32'(MY_ID));
        check("flit_seq",  32'(f.seq),  32'(k));
        check("flit_rsvd", 32'(f.rsvd), 32'd0);
        check("flit_ts",   32'(f.ts),   32'(tb_cyc));
        check("idle_gap",  32'(gap),    32'(exp_gap));
        $display("flit k=%0d dst=%0d src=%0d seq=%0d ts=%0d gap=%0d", k, f.dst, f.src, f.seq, f.ts, gap);
    endtask

    task automatic do_flush;
        flush = 1'b1;
        step;
        flush = 1'b0;
        check("flush_valid",  32'(valid_p2r),        32'd0);
        check("flush_finish", 32'(task_send_finish), 32'd0);
        check("flush_data",   data_p2r,              32'd0);
    endtask

    // Runs one task from IDLE, tracking it with the transaction model.
    // lat = sample index (1 = first sample after the enable edge) where finish is seen.
    task automatic run_task(input logic [2:0] n, input logic [3:0] rt, input logic [3:0] md,
                            input logic [23:0] ds, input int full_pct,
                            output int lat, output int nflits, output logic [2:0] last_dst);
        int          k;
        int          gap;
        int          cyc;
        logic        prev_valid;
        logic        prev_stall;
        logic        done;
        logic [31:0] prev_data;
        enable   = 1'b1;
        send_num = n;
        rate     = rt;
        mode     = md;
        dst_seq  = ds;
        full     = 1'b0;
        step;
        // Scramble the config inputs: the latched copies must be used.
        enable   = 1'b0;
        send_num = 3'($urandom);
        rate     = 4'($urandom);
        mode     = 4'($urandom);
        dst_seq  = 24'($urandom);
        k = 0; gap = 0; cyc = 1; prev_valid = 1'b0; prev_stall = 1'b0; done = 1'b0;
        prev_data = '0; lat = -1; nflits = 0; last_dst = '0;
        while (!done) begin
            if (valid_p2r) begin
                if (k >= int'(n)) begin
                    check("extra_flit_valid", 32'(valid_p2r), 32'd0);
                    done = 1'b1;
                end else begin
                    if (prev_valid && prev_stall) begin
                        check("hold_data", data_p2r, prev_data);
                    end else begin
                        check_new_flit(k, md, ds, gap, (k == 0) ? 0 : int'(rt));
                        nflits++;
                    end
                    full       = ($urandom_range(99) < full_pct);
                    prev_stall = full;
                    prev_data  = data_p2r;
                    if (!full) begin
                        last_dst = model_dst(md, ds, k);
                        k++;
                        gap = 0;
                    end
                end
            end else begin
                if (prev_valid && prev_stall) begin
                    check("valid_held_under_full", 32'(valid_p2r), 32'd1);
                end
                full = ($urandom_range(99) < full_pct);
                if (k == int'(n)) begin
                    check("finish_after_last", 32'(task_send_finish), 32'd1);
                    lat  = cyc;
                    done = 1'b1;
                end else begin
                    check("finish_not_early", 32'(task_send_finish), 32'd0);
                    gap++;
                end
            end
            prev_valid = valid_p2r;
            if (!done) begin
                if (cyc >= 1000) begin
                    checks++;
                    errors++;
                    $display("FAIL task_timeout: accepted %0d of %0d flits after %0d cycles", k, n, cyc);
                    done = 1'b1;
                end else begin
                    step;
                    cyc++;
                end
            end
        end
        full = 1'b0;
        $display("task n=%0d rate=%0d mode=%0h dst_seq=%06h accepted=%0d finish_at=%0d", n, rt, md, ds, k, lat);
        // Once finished, enable must be ignored until flush.
        enable   = 1'b1;
        send_num = 3'd5;
        repeat (2) begin
            step;
            check("done_ignores_enable", 32'(valid_p2r),        32'd0);
            check("done_holds_finish",   32'(task_send_finish), 32'd1);
        end
        enable = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  n;
        logic [3:0]  rt;
        logic [3:0]  md;
        logic [23:0] ds;
        int          exp_lat;
        int          exp_flits;
        logic [2:0]  exp_last;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int          lat;
        int          nfl;
        logic [2:0]  ldst;
        logic [31:0] d0;
        flit_t       f;

        // exp_lat = (n-1)*(rate+1)+2 for n>0, 1 for an empty task (full held low).
        vecs[0] = '{3'd4, 4'd0,  4'b0000, 24'hFAC688, 5,  4, 3'd3};
        vecs[1] = '{3'd2, 4'd3,  4'b0000, 24'hFAC688, 6,  2, 3'd1};
        vecs[2] = '{3'd7, 4'd0,  4'b1011, 24'hFAC68D, 8,  7, 3'd5};
        vecs[3] = '{3'd0, 4'd2,  4'b0000, 24'hFAC688, 1,  0, 3'd0};
        vecs[4] = '{3'd3, 4'd1,  4'b0000, 24'h6DB6DB, 6,  3, 3'd3};
        vecs[5] = '{3'd5, 4'd15, 4'b0000, 24'hFAC688, 66, 5, 3'd4};

        rst_n = 1'b0; enable = 1'b0; flush = 1'b0; mode = '0; send_num = '0;
        rate = '0; dst_seq = '0; full = 1'b0;
        step;
        step;
        check("reset_valid",  32'(valid_p2r),        32'd0);
        check("reset_data",   data_p2r,              32'd0);
        check("reset_finish", 32'(task_send_finish), 32'd0);
        rst_n = 1'b1;
        step;

        // Directed table, no backpressure.
        for (int i = 0; i < 6; i++) begin
            do_flush;
            run_task(vecs[i].n, vecs[i].rt, vecs[i].md, vecs[i].ds, 0, lat, nfl, ldst);
            check("tbl_finish_latency", 32'(lat),  32'(vecs[i].exp_lat));
            check("tbl_flit_count",     32'(nfl),  32'(vecs[i].exp_flits));
            check("tbl_last_dst",       32'(ldst), 32'(vecs[i].exp_last));
        end
        do_flush;

        // Backpressure hold for 5 cycles, one transfer, then reset mid-SEND under full.
        full = 1'b1; enable = 1'b1; send_num = 3'd3; rate = 4'd0; mode = 4'd0; dst_seq = 24'hFAC688;
        step;
        enable = 1'b0;
        check("stall_first_valid", 32'(valid_p2r), 32'd1);
        d0 = data_p2r;
        for (int i = 1; i < 5; i++) begin
            step;
            check("stall_hold_valid", 32'(valid_p2r), 32'd1);
            check("stall_hold_data",  data_p2r,       d0);
        end
        full = 1'b0;
        step;
        f = data_p2r;
        check("stall_release_valid", 32'(valid_p2r), 32'd1);
        check("stall_release_seq",   32'(f.seq),     32'd1);
        full = 1'b1;
        step;
        step;
        f = data_p2r;
        check("stall_single_transfer_seq", 32'(f.seq), 32'd1);
        $display("stall sequence: held 5 cycles, one transfer, seq now %0d", f.seq);
        rst_n = 1'b0;
        step;
        check("reset_midsend_valid",  32'(valid_p2r),        32'd0);
        check("reset_midsend_data",   data_p2r,              32'd0);
        check("reset_midsend_finish", 32'(task_send_finish), 32'd0);
        rst_n = 1'b1;
        full  = 1'b0;
        step;

        // Flush during GAP with three flits still owed, then restart from seq 0.
        enable = 1'b1; send_num = 3'd5; rate = 4'd4; mode = 4'd0; dst_seq = 24'hFAC688;
        step;
        enable = 1'b0;
        f = data_p2r;
        check("gapflush_first_valid", 32'(valid_p2r), 32'd1);
        check("gapflush_first_seq",   32'(f.seq),     32'd0);
        repeat (5) step;
        f = data_p2r;
        check("gapflush_second_valid", 32'(valid_p2r), 32'd1);
        check("gapflush_second_seq",   32'(f.seq),     32'd1);
        check("gapflush_second_dst",   32'(f.dst),     32'd1);
        step;
        check("gapflush_in_gap", 32'(valid_p2r), 32'd0);
        do_flush;
        repeat (2) begin
            step;
            check("gapflush_stays_idle", 32'(valid_p2r), 32'd0);
        end
        $display("flush in GAP: returned to IDLE, restarting");
        run_task(3'd2, 4'd0, 4'd0, 24'hFAC688, 0, lat, nfl, ldst);
        check("restart_flit_count", 32'(nfl),  32'd2);
        check("restart_last_dst",   32'(ldst), 32'd1);
        do_flush;

        // Flush in the same cycle as a transfer counts as a flush.
        enable = 1'b1; send_num = 3'd3; rate = 4'd0; mode = 4'd0; dst_seq = 24'hFAC688;
        step;
        enable = 1'b0;
        check("flushxfer_valid_before", 32'(valid_p2r), 32'd1);
        flush = 1'b1;
        full  = 1'b0;
        step;
        flush = 1'b0;
        check("flushxfer_valid",  32'(valid_p2r),        32'd0);
        check("flushxfer_finish", 32'(task_send_finish), 32'd0);
        step;
        check("flushxfer_idle", 32'(valid_p2r), 32'd0);
        $display("flush with concurrent transfer: dropped");

        // Randomized tasks with random backpressure.
        for (int i = 0; i < 12; i++) begin
            logic [2:0]  rn;
            logic [3:0]  rr;
            logic [3:0]  rm;
            logic [23:0] rd;
            rn = 3'($urandom_range(7));
            rr = 4'($urandom_range(5));
            rm = 4'($urandom);
            rd = 24'($urandom);
            do_flush;
            run_task(rn, rr, rm, rd, 35, lat, nfl, ldst);
            check("rand_flit_count", 32'(nfl), 32'(rn));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
